bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 116 +++++++++++
 tb/tb_bcd_display_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Three-digit BCD to multiplexed 7-segment scanner with registered outputs and a dead-time gap at each slot start.
// Optional leading-zero blanking is compiled in when BCD_SCAN_LZB_EN is defined.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        err
);

  // state         | meaning
  // SLOT_UNITS    | scanning units digit    (an bit 0)
  // SLOT_TENS     | scanning tens digit     (an bit 1)
  // SLOT_HUNDREDS | scanning hundreds digit (an bit 2)
  localparam logic [1:0] SLOT_UNITS    = 2'd0;
  localparam logic [1:0] SLOT_TENS     = 2'd1;
  localparam logic [1:0] SLOT_HUNDREDS = 2'd2;

  localparam int unsigned          CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]           SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;

  logic [11:0]      disp;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [3:0] digit;
  logic [2:0] an_onehot;
  logic       blank;
  logic [6:0] seg_hi;
  logic [6:0] seg_nxt;
  logic [2:0] an_nxt;
  logic       err_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  always_comb begin
    digit     = disp[3:0];
    an_onehot = 3'b001;
    case (idx)
      SLOT_TENS: begin
        digit     = disp[7:4];
        an_onehot = 3'b010;
      end
      SLOT_HUNDREDS: begin
        digit     = disp[11:8];
        an_onehot = 3'b100;
      end
      default: begin
        digit     = disp[3:0];
        an_onehot = 3'b001;
      end
    endcase

    blank = 1'b0;
`ifdef BCD_SCAN_LZB_EN
    // Tens only blanks when hundreds is also zero, so "105" keeps its inner zero.
    if (idx == SLOT_HUNDREDS && disp[11:8] == 4'd0)
      blank = 1'b1;
    if (idx == SLOT_TENS && disp[11:8] == 4'd0 && disp[7:4] == 4'd0)
      blank = 1'b1;
`endif

    seg_hi  = blank ? 7'b0000000 : seg_decode(digit);
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_nxt  = (cnt == '0) ? 3'b000 : an_onehot;
    err_nxt = (disp[3:0] > 4'd9) || (disp[7:4] > 4'd9) || (disp[11:8] > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp <= 12'h000;
      cnt  <= '0;
      idx  <= SLOT_UNITS;
      seg  <= SEG_OFF;
      an   <= 3'b000;
      err  <= 1'b0;
    end else begin
      if (load)
        disp <= bcd;

      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == SLOT_HUNDREDS) ? SLOT_UNITS : idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      seg <= seg_nxt;
      an  <= an_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan (SCAN_DIV=4, active-high segments).
// Each stimulus cycle queues the expected outputs; a negedge monitor pops and compares.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        err;

  bcd_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .bcd   (bcd),
    .seg   (seg),
    .an    (an),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    int         tag;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_tag  = 0;
  int   cyc_no   = 0;

  // Bench-side view of scan position and latched value.
  int          k_m    = 0;
  logic [11:0] disp_m = 12'h000;

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "idle_after_reset";
      2: return "load_255";
      3: return "load_0A7";
      4: return "load_007";
      5: return "load_123_on_wrap";
      6: return "back_to_back_load";
      7: return "reset_mid_tens";
      default: return "after_reset2";
    endcase
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic step(input logic r, input logic l, input logic [11:0] b);
    exp_t e;
    int   slot;
    int   pos;
    rst_n = r;
    load  = l;
    bcd   = b;
    @(posedge clk);
    #1;
    cyc_no++;
    e.tag = cur_tag;
    e.cyc = cyc_no;
    if (!r) begin
      e.seg  = 7'b0000000;
      e.an   = 3'b000;
      e.err  = 1'b0;
      k_m    = 0;
      disp_m = 12'h000;
    end else begin
      slot  = (k_m / 4) % 3;
      pos   = k_m % 4;
      e.an  = (pos == 0) ? 3'b000 : 3'(1 << slot);
      e.seg = seg_ref(disp_m[slot*4 +: 4]);
`ifdef BCD_SCAN_LZB_EN
      if (slot == 2 && disp_m[11:8] == 4'd0) e.seg = 7'b0000000;
      if (slot == 1 && disp_m[11:4] == 8'h00) e.seg = 7'b0000000;
`endif
      e.err = (disp_m[3:0] > 4'd9) || (disp_m[7:4] > 4'd9) || (disp_m[11:8] > 4'd9);
      if (l) disp_m = b;
      k_m++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'h000);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (seg !== e.seg) begin
        failures++;
        $display("FAIL %s seg cyc=%0d got=%b exp=%b", tag_name(e.tag), e.cyc, seg, e.seg);
      end
      checks++;
      if (an !== e.an) begin
        failures++;
        $display("FAIL %s an cyc=%0d got=%b exp=%b", tag_name(e.tag), e.cyc, an, e.an);
      end
      checks++;
      if (err !== e.err) begin
        failures++;
        $display("FAIL %s err cyc=%0d got=%b exp=%b", tag_name(e.tag), e.cyc, err, e.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    bcd   = 12'h000;

    cur_tag = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h000);

    cur_tag = 1;
    idle(13);

    cur_tag = 2;
    step(1'b1, 1'b1, 12'h255);
    idle(13);

    cur_tag = 3;
    step(1'b1, 1'b1, 12'h0A7);
    idle(13);

    cur_tag = 4;
    step(1'b1, 1'b1, 12'h007);
    idle(13);

    // Align so the load lands on the edge where the prescaler wraps.
    cur_tag = 5;
    for (int i = 0; i < 4 && (k_m % 4) != 3; i++) idle(1);
    step(1'b1, 1'b1, 12'h123);
    idle(13);

    cur_tag = 6;
    step(1'b1, 1'b1, 12'h111);
    step(1'b1, 1'b1, 12'h468);
    idle(13);

    cur_tag = 7;
    step(1'b1, 1'b1, 12'h3C0);
    for (int i = 0; i < 12 && !((k_m % 4) == 2 && ((k_m / 4) % 3) == 1); i++) idle(1);
    step(1'b0, 1'b1, 12'h999);

    cur_tag = 8;
    idle(13);

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
